regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: INIT_CLEAR, default 1, 1 = run the post-reset clear sweep of r0..r15, 0 = skip it.
REQ-002 Port: clk  input  1  single clock, all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: a_valid  input  1  writeback request from the ALU path.
REQ-005 Port: a_reg  input  4  destination register index for the ALU path.
REQ-006 Port: a_data  input  16  write data for the ALU path.
REQ-007 Port: a_ready  output  1  ALU request accepted this cycle.
REQ-008 Port: b_valid / b_reg / b_data / b_ready  in/in/in/out  1/4/16/1  same as the A signals, for the memory-load path.
REQ-009 Port: WriteReg  output  1  register file write enable.
REQ-010 Port: DstReg  output  4  register file write index.
REQ-011 Port: DstData  output  16  register file write data.
REQ-012 Port: init_done  output  1  high once the clear sweep is complete.
REQ-013 Port: conflict_cnt  output  8  saturating count of contention cycles.

Function
REQ-014 The block SHALL have exactly two states, INIT and ARB; on reset it enters INIT if INIT_CLEAR=1, otherwise ARB.
REQ-015 In INIT, a 4-bit sweep counter SHALL drive one write per cycle: WriteReg=1, DstReg=counter, DstData=16'h0000, for counter 0..15 (16 cycles).
REQ-016 After the write to r15, the block SHALL go to ARB and set init_done=1 on the next cycle; init_done SHALL stay 1 until reset.
REQ-017 In INIT, a_ready and b_ready SHALL both be 0.
REQ-018 In ARB, the ready outputs SHALL be combinational from the valids and the priority flop:
 - only one valid: that side gets ready=1.
 - both valid: the side not granted last gets ready=1.
 - at most one ready is high in any cycle.
REQ-019 A transfer SHALL occur on a cycle where valid and ready are both 1.
REQ-020 A requester SHALL hold valid, reg and data stable until its transfer; the arbiter SHALL NOT drop a pending request.
REQ-021 The write outputs SHALL be registered (one-cycle latency): on the cycle after a transfer, WriteReg=1 and DstReg/DstData carry the transferred reg/data; otherwise WriteReg=0.
REQ-022 A transfer with reg=4'h0 SHALL complete the handshake, update priority and give WriteReg=0 next cycle (r0 is hardwired to zero).
REQ-023 The last-grant flop SHALL update on every transfer, including r0 transfers.
REQ-024 The last-grant flop SHALL reset to B, so A wins the first contention.
REQ-025 conflict_cnt SHALL increment by 1 on each ARB cycle where a_valid and b_valid are both 1, and SHALL saturate at 8'hFF.
REQ-026 When both requesters target the same register on back-to-back grants, both writes SHALL be issued in grant order; the later write wins in the register file.
REQ-027 While WriteReg=0, DstReg and DstData SHALL hold their last values.

Reset
REQ-028 Asserting rst_n low SHALL, immediately and independent of clk, set:
 - WriteReg=0, DstReg=0, DstData=0.
 - a_ready=0, b_ready=0.
 - init_done=0, conflict_cnt=0.
 - sweep counter=0, last-grant=B.
REQ-029 A reset asserted mid-INIT or mid-transfer SHALL abandon the operation; after release, the sweep restarts at r0 and no partial write is issued.

Verification
REQ-030 Reset release with INIT_CLEAR=1 -> WriteReg=1 for 16 consecutive cycles, DstReg 0..15, DstData=0000; then init_done=1; readies low throughout.
REQ-031 ARB, a_valid only (reg 3, DEAD) -> a_ready=1 same cycle; next cycle WriteReg=1, DstReg=3, DstData=DEAD.
REQ-032 Both valid for 4 cycles (A: r1 BEEF, B: r2 DEAD, new data each grant) -> grants A,B,A,B; conflict_cnt=4 if both stay valid for all 4 cycles.
REQ-033 b_valid with reg 0, data FFFF -> b_ready=1, next cycle WriteReg=0; a following contention grants A.
REQ-034 Both valid held for 300 cycles -> conflict_cnt stops at FF.
REQ-035 rst_n pulsed low at sweep index 7 -> outputs clear immediately; after release the sweep restarts at DstReg=0 and init_done is set only after r15.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a 16x16 register file: round-robin between ALU (A) and load (B)
// requesters, with an optional post-reset sweep that clears r0..r15.
module regfile_wb_arbiter #(
    parameter logic INIT_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic [3:0]  a_reg,
    input  logic [15:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [3:0]  b_reg,
    input  logic [15:0] b_data,
    output logic        b_ready,
    output logic        WriteReg,
    output logic [3:0]  DstReg,
    output logic [15:0] DstData,
    output logic        init_done,
    output logic [7:0]  conflict_cnt
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_ARB  = 1'b1;

    logic [0:0] state;
    logic [3:0] sweep_cnt;
    logic       last_b;     // 1 = B was granted most recently
    logic       both_valid;
    logic       a_fire;
    logic       b_fire;

    assign both_valid = a_valid && b_valid;
    assign a_fire     = a_valid && a_ready;
    assign b_fire     = b_valid && b_ready;

    // NOTE: every output gets a default before the branches so no latch is inferred.
    // rst_n is included so the readies fall immediately on reset even when the sweep is skipped.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (rst_n && state == ST_ARB) begin
            if (both_valid) begin
                a_ready = last_b;
                b_ready = !last_b;
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= INIT_CLEAR ? ST_INIT : ST_ARB;
            sweep_cnt    <= 4'h0;
            last_b       <= 1'b1;
            WriteReg     <= 1'b0;
            DstReg       <= 4'h0;
            DstData      <= 16'h0000;
            init_done    <= 1'b0;
            conflict_cnt <= 8'h00;
        end else begin
            case (state)
                ST_INIT: begin
                    WriteReg  <= 1'b1;
                    DstReg    <= sweep_cnt;
                    DstData   <= 16'h0000;
                    sweep_cnt <= sweep_cnt + 4'h1;
                    if (sweep_cnt == 4'hF) begin
                        state <= ST_ARB;
                    end
                end
                default: begin
                    init_done <= 1'b1;
                    WriteReg  <= 1'b0;
                    // r0 is hardwired to zero: its transfers update priority but write nothing
                    if (a_fire) begin
                        last_b <= 1'b0;
                        if (a_reg != 4'h0) begin
                            WriteReg <= 1'b1;
                            DstReg   <= a_reg;
                            DstData  <= a_data;
                        end
                    end else if (b_fire) begin
                        last_b <= 1'b1;
                        if (b_reg != 4'h0) begin
                            WriteReg <= 1'b1;
                            DstReg   <= b_reg;
                            DstData  <= b_data;
                        end
                    end
                    if (both_valid && conflict_cnt != 8'hFF) begin
                        conflict_cnt <= conflict_cnt + 8'h01;
                    end
                end
            endcase
        end
    end

endmodule
